// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_pkg
// Brief   : 800x600@72Hz timing constants and shared video typedefs.
// Revision: 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int c_h_visible = 800;
    localparam int c_h_front   = 56;
    localparam int c_h_sync    = 120;
    localparam int c_h_back    = 64;
    localparam int c_v_visible = 600;
    localparam int c_v_front   = 37;
    localparam int c_v_sync    = 6;
    localparam int c_v_back    = 23;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef logic [10:0] h_coord_t;
    typedef logic [9:0]  v_coord_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module  : vga_axis_counter
// Brief   : One timing axis: wrapping position counter with visible/sync decode.
// Revision: 1.0
// ============================================================================
module vga_axis_counter #(
    parameter int W          = 11,
    parameter int TOTAL      = 1040,
    parameter int VIS        = 800,
    parameter int SYNC_START = 856,
    parameter int SYNC_LEN   = 120
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         i_step,
    output logic [W-1:0] o_cnt,
    output logic         o_visible,
    output logic         o_sync,
    output logic         o_wrap
);

    localparam int             c_W1         = W + 1;
    localparam logic [W-1:0]   c_LAST       = W'(TOTAL - 1);
    localparam logic [c_W1-1:0] c_VIS       = c_W1'(VIS);
    localparam logic [c_W1-1:0] c_SYNC_START = c_W1'(SYNC_START);
    localparam logic [c_W1-1:0] c_SYNC_END   = c_W1'(SYNC_START + SYNC_LEN);

    logic [W-1:0] r_cnt;
    logic         r_visible;
    logic [W-1:0] w_next;
    logic         w_wrap;

    assign w_wrap = (r_cnt == c_LAST);
    assign w_next = w_wrap ? '0 : r_cnt + W'(1);

    // Reset parks the counter on its last position so the first step lands on 0.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt     <= c_LAST;
            r_visible <= 1'b0;
        end else if (i_step) begin
            r_cnt     <= w_next;
            r_visible <= ({1'b0, w_next} < c_VIS);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_visible = r_visible;
    assign o_wrap    = w_wrap;
    assign o_sync    = ({1'b0, r_cnt} >= c_SYNC_START) && ({1'b0, r_cnt} < c_SYNC_END);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : VGA pixel timing, coordinate issue and registered RGB/sync output.
// Revision: 1.0
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = c_h_visible,
    parameter int   H_FRONT   = c_h_front,
    parameter int   H_SYNC    = c_h_sync,
    parameter int   H_BACK    = c_h_back,
    parameter int   V_VISIBLE = c_v_visible,
    parameter int   V_FRONT   = c_v_front,
    parameter int   V_SYNC    = c_v_sync,
    parameter int   V_BACK    = c_v_back,
    parameter logic SYNC_POL  = 1'b1,
    parameter int   CLK_DIV   = 1
) (
    input  logic        clk,
    input  logic        arst,
    output logic [10:0] o_h_coord,
    output logic [9:0]  o_v_coord,
    output logic        o_disp_enbl,
    input  logic [3:0]  i_red,
    input  logic [3:0]  i_green,
    input  logic [3:0]  i_blue,
    output logic [3:0]  o_vga_r,
    output logic [3:0]  o_vga_g,
    output logic [3:0]  o_vga_b,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    generate
        if (c_H_TOTAL > 2048 || c_V_TOTAL > 1024 || CLK_DIV < 1) begin : g_cfg_check
            $error("vga_timing_gen: unsupported timing/divider configuration");
        end
    endgenerate

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_pix_en;

    assign w_pix_en = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_div_cnt <= '0;
        end else if (w_pix_en) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    h_coord_t w_h_cnt;
    v_coord_t w_v_cnt;
    logic     w_h_vis, w_v_vis, w_hs0, w_vs0, w_h_wrap, w_v_wrap;
    logic     w_disp_enbl;

    vga_axis_counter #(
        .W(11), .TOTAL(c_H_TOTAL), .VIS(H_VISIBLE),
        .SYNC_START(H_VISIBLE + H_FRONT), .SYNC_LEN(H_SYNC)
    ) u_h_axis (
        .clk(clk), .arst(arst), .i_step(w_pix_en),
        .o_cnt(w_h_cnt), .o_visible(w_h_vis), .o_sync(w_hs0), .o_wrap(w_h_wrap)
    );

    vga_axis_counter #(
        .W(10), .TOTAL(c_V_TOTAL), .VIS(V_VISIBLE),
        .SYNC_START(V_VISIBLE + V_FRONT), .SYNC_LEN(V_SYNC)
    ) u_v_axis (
        .clk(clk), .arst(arst), .i_step(w_pix_en & w_h_wrap),
        .o_cnt(w_v_cnt), .o_visible(w_v_vis), .o_sync(w_vs0), .o_wrap(w_v_wrap)
    );

    // Both visibility flags are registered alongside their counters.
    assign w_disp_enbl = w_h_vis & w_v_vis;

    rgb12_t r_rgb;
    logic   r_hsync, r_vsync, r_frame_start;

    // One pixel of latency from coordinates to pins; syncs delayed to match colour.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rgb         <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_en & w_h_wrap & w_v_wrap;
            if (w_pix_en) begin
                r_rgb   <= w_disp_enbl ? '{r: i_red, g: i_green, b: i_blue} : '0;
                r_hsync <= w_hs0 ? SYNC_POL : ~SYNC_POL;
                r_vsync <= w_vs0 ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign o_h_coord     = w_h_cnt;
    assign o_v_coord     = w_v_cnt;
    assign o_disp_enbl   = w_disp_enbl;
    assign o_vga_r       = r_rgb.r;
    assign o_vga_g       = r_rgb.g;
    assign o_vga_b       = r_rgb.b;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire
